// File: rtl/imm_extend_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared types and constants for the pipelined immediate
//                generator. Imported by the interface, the decoder and the
//                top-level pipe.
//  Revision    : 1.0  initial release
// ============================================================================
package imm_pkg;

    // Number of instruction bits presented to the generator: Instr[31:7].
    localparam int c_INSTR_W = 25;
    // Bit offset of the lowest presented instruction bit.
    localparam int c_INSTR_LSB = 7;
    // Width of the format select.
    localparam int c_SRC_W = 3;

    // Codes 5..7 are unassigned and reported as illegal.
    typedef enum logic [c_SRC_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extend_pipe_if
//  Description : Handshake bundle for imm_extend_pipe.
//                Upstream side : in_valid / in_ready / Instr / ImmSrc / in_tag
//                Downstream    : out_valid / out_ready / ImmExt / out_tag /
//                                out_illegal, plus the illegal_cnt status.
//                modport master : the environment (drives requests, out_ready)
//                modport slave  : the immediate generator
//  Revision    : 1.0  initial release
// ============================================================================
interface imm_extend_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [c_INSTR_W-1:0]   Instr;
    logic [c_SRC_W-1:0]     ImmSrc;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        ImmExt;
    logic [TAG_W-1:0]       out_tag;
    logic                   out_illegal;
    logic [CNT_W-1:0]       illegal_cnt;

    modport master (
        output in_valid, Instr, ImmSrc, in_tag, out_ready,
        input  in_ready, out_valid, ImmExt, out_tag, out_illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, Instr, ImmSrc, in_tag, out_ready,
        output in_ready, out_valid, ImmExt, out_tag, out_illegal, illegal_cnt
    );

endinterface : imm_extend_pipe_if
`default_nettype wire

// File: rtl/imm_extend_pipe_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode
//  Description : Combinational immediate extraction and sign extension for
//                the I/S/B/J/U formats. Also used by the branch predictor.
//  Ports       : i_instr   Instr[31:7]
//                i_imm_src format select (imm_src_t encoding)
//                o_imm_ext sign-extended immediate, XLEN wide
//                o_illegal format select is not one of I/S/B/J/U
//  Revision    : 1.0  initial release
// ============================================================================
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [c_INSTR_W-1:0] i_instr,
    input  wire logic [c_SRC_W-1:0]   i_imm_src,
    output logic      [XLEN-1:0]      o_imm_ext,
    output logic                      o_illegal
);

    localparam int c_O = c_INSTR_LSB;

    // Every format is first built as a 32-bit signed value; widening to
    // XLEN is then a single sign extension (U included, which is what RV64
    // requires for LUI/AUIPC).
    logic [31:0] w_imm32;
    logic        w_s;

    assign w_s = i_instr[31-c_O];

    always_comb begin
        w_imm32   = '0;
        o_illegal = 1'b0;
        case (i_imm_src)
            IMM_I: w_imm32 = {{20{w_s}}, i_instr[31-c_O:20-c_O]};
            IMM_S: w_imm32 = {{20{w_s}}, i_instr[31-c_O:25-c_O], i_instr[11-c_O:7-c_O]};
            IMM_B: w_imm32 = {{20{w_s}}, i_instr[7-c_O], i_instr[30-c_O:25-c_O],
                              i_instr[11-c_O:8-c_O], 1'b0};
            IMM_J: w_imm32 = {{12{w_s}}, i_instr[19-c_O:12-c_O], i_instr[20-c_O],
                              i_instr[30-c_O:21-c_O], 1'b0};
            IMM_U: w_imm32 = {i_instr[31-c_O:12-c_O], 12'b0};
            default: o_illegal = 1'b1;
        endcase
    end

    if (XLEN > 32) begin : g_sext
        assign o_imm_ext = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_nosext
        assign o_imm_ext = w_imm32;
    end

endmodule : imm_decode
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extend_pipe
//  Description : Pipelined immediate generator. Decodes Instr[31:7]/ImmSrc,
//                registers the result one cycle later and absorbs downstream
//                stalls with a 2-entry skid buffer (output reg + skid reg).
//  Ports       : CLK    clock, rising edge
//                reset  asynchronous active-high reset
//                bus    imm_extend_pipe_if.slave (handshakes, result, counter)
//  Revision    : 1.0  initial release
// ============================================================================
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  wire logic        CLK,
    input  wire logic        reset,
    imm_extend_pipe_if.slave bus
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_xlen_check
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic               illegal;
        logic [TAG_W-1:0]   tag;
        logic [XLEN-1:0]    imm;
    } imm_result_t;

    logic [XLEN-1:0] w_dec_imm;
    logic            w_dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_instr   (bus.Instr),
        .i_imm_src (bus.ImmSrc),
        .o_imm_ext (w_dec_imm),
        .o_illegal (w_dec_illegal)
    );

    imm_result_t      r_or, r_sr, w_or_nxt, w_sr_nxt, w_new;
    logic             r_or_valid, r_sr_valid, w_or_valid_nxt, w_sr_valid_nxt;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_acc, w_pop;

    assign w_new = '{illegal: w_dec_illegal, tag: bus.in_tag, imm: w_dec_imm};
    assign w_acc = bus.in_valid & r_in_ready;
    assign w_pop = r_or_valid & bus.out_ready;

    always_comb begin
        w_or_nxt       = r_or;
        w_or_valid_nxt = r_or_valid;
        w_sr_nxt       = r_sr;
        w_sr_valid_nxt = r_sr_valid;
        if (!r_or_valid) begin
            if (w_acc) begin
                w_or_nxt       = w_new;
                w_or_valid_nxt = 1'b1;
            end
        end else if (w_pop) begin
            if (r_sr_valid) begin
                // in_ready was low, so nothing new can arrive this edge.
                w_or_nxt       = r_sr;
                w_sr_valid_nxt = 1'b0;
            end else if (w_acc) begin
                w_or_nxt       = w_new;
            end else begin
                w_or_valid_nxt = 1'b0;
            end
        end else if (w_acc) begin
            w_sr_nxt       = w_new;
            w_sr_valid_nxt = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_acc && w_dec_illegal && (r_cnt != {CNT_W{1'b1}}))
            w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_or       <= '0;
            r_sr       <= '0;
            r_or_valid <= 1'b0;
            r_sr_valid <= 1'b0;
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_or       <= w_or_nxt;
            r_sr       <= w_sr_nxt;
            r_or_valid <= w_or_valid_nxt;
            r_sr_valid <= w_sr_valid_nxt;
            // Registered copy of "skid slot free" keeps out_ready off the
            // in_ready path and holds in_ready low until the first edge
            // after reset is released.
            r_in_ready <= !w_sr_valid_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_or_valid;
    assign bus.ImmExt      = r_or.imm;
    assign bus.out_tag     = r_or.tag;
    assign bus.out_illegal = r_or.illegal;
    assign bus.illegal_cnt = r_cnt;

endmodule : imm_extend_pipe
`default_nettype wire
